des_stream_ctrl: RTL and testbench
==================================

Name: des_stream_ctrl

Overview:
- Sequencing controller that streams 64-bit image blocks through the combinational DES core (DES_Implementation) one at a time.
- Holds the key register and applies input/output valid/ready handshakes.
- Waits a fixed settle time per block and stops after a programmed block count (one full image).
- Sits between the image block source (file/memory reader) and the ciphertext sink; the DES core is instantiated alongside and wired to the core_* ports.

Parameters:
- NUM_BLOCKS, 131072: number of 64-bit blocks per run (one image).
- CNT_W, 18: width of the block counter; must satisfy 2^CNT_W > NUM_BLOCKS.
- CORE_LAT, 1: settle cycles allowed for the DES core after core_msg changes. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; honoured only in IDLE or DONE.
- key_wr  input  1  load key_in into the key register; honoured only in IDLE or DONE.
- key_in  input  64  DES key, bit order [64:1].
- iv_in  input  64  chaining IV, used only with CBC_CHAIN_EN.
- in_valid  input  1  source has a plaintext block.
- in_data  input  64  plaintext block [64:1].
- in_ready  output  1  controller accepts a block this cycle.
- out_valid  output  1  ciphertext block available.
- out_data  output  64  ciphertext block [64:1].
- out_ready  input  1  sink accepts out_data.
- core_msg  output  64  registered message to the DES core.
- core_key  output  64  registered key to the DES core.
- core_enigma  input  64  DES core result.
- busy  output  1  high in ACCEPT, WAIT and OUTPUT.
- done  output  1  high in DONE.
- blk_cnt  output  CNT_W  blocks delivered in the current run.

Behaviour:
- Reset values:
  - State IDLE.
  - in_ready, out_valid, busy and done are 0.
  - out_data, core_msg, core_key, blk_cnt and the chain register are 0.
  - Reset mid-run discards any in-flight block; no partial output is produced.
- States:
  - IDLE: start goes to ACCEPT; blk_cnt is cleared to 0.
  - ACCEPT: in_ready=1. When in_valid and in_ready are both high, core_msg is loaded with in_data (XOR chain register under CBC), the settle counter is loaded with CORE_LAT-1, and the state goes to WAIT.
  - WAIT: in_ready=0. The settle counter decrements each cycle. At 0, out_data is loaded with core_enigma, out_valid is set and the state goes to OUTPUT.
  - OUTPUT: out_valid and out_data stay stable until out_ready. On the handshake, out_valid clears and blk_cnt increments. If the new blk_cnt equals NUM_BLOCKS the state goes to DONE, otherwise to ACCEPT.
  - DONE: done=1 and blk_cnt holds. start returns to ACCEPT with blk_cnt cleared.
- Latency:
  - Input handshake at edge T gives out_valid high after edge T+CORE_LAT+1.
  - Minimum cycles per block is CORE_LAT+3 with out_ready held high.
- Key handling:
  - core_key is driven from the key register.
  - key_wr outside IDLE/DONE is ignored; the key cannot change mid-run.
  - key_wr and start in the same cycle: the key is written and the run uses the new key.
- start outside IDLE/DONE is ignored.
- in_valid is ignored outside ACCEPT; in_data needs to be stable only on the handshake cycle.
- out_ready low in OUTPUT stalls indefinitely; no data is lost.
- blk_cnt never wraps because the run stops at NUM_BLOCKS.
- NUM_BLOCKS=1: DONE is entered after the first output handshake.

Optional Feature:
- Macro: CBC_CHAIN_EN.
- Defined:
  - On the start that leaves IDLE/DONE, the chain register is loaded from iv_in.
  - core_msg = in_data XOR chain.
  - On each output handshake, chain is loaded with out_data. This gives CBC encryption of the image.
- Undefined:
  - ECB only. core_msg = in_data.
  - iv_in is ignored and the chain register is absent.

Test Plan:
- Known-answer test:
  - Stimulus: key_wr with key 133457799BBCDFF1, start, one block 0123456789ABCDEF, out_ready=1, CORE_LAT=1.
  - Required response: out_data = 85E813540F0AB405, out_valid rises 2 cycles after the input handshake, blk_cnt=1.
- Full run:
  - Stimulus: NUM_BLOCKS=4, four blocks back-to-back, out_ready=1.
  - Required response: four outputs matching the reference model; done=1 after the 4th handshake; blk_cnt=4; in_ready=0 in DONE.
- Backpressure:
  - Stimulus: out_ready low for 10 cycles in OUTPUT.
  - Required response: out_valid and out_data stable throughout; in_ready=0; blk_cnt unchanged until the handshake.
- Key lock:
  - Stimulus: key_wr with FFFFFFFFFFFFFFFF during WAIT.
  - Required response: core_key unchanged and output uses the old key. key_wr in DONE updates core_key next cycle.
- Reset mid-run:
  - Stimulus: rst asserted in WAIT.
  - Required response: next cycle state IDLE, out_valid=0, blk_cnt=0, core_key=0.
- CBC (CBC_CHAIN_EN defined):
  - Stimulus: iv_in=0000000000000000, two identical plaintext blocks 0123456789ABCDEF.
  - Required response: first output = 85E813540F0AB405; second output = DES(0123456789ABCDEF XOR 85E813540F0AB405) and differs from the first.

Source files
------------

// File: rtl/des_stream_ctrl.sv
// -----------------------------------------------------------------------------
// des_stream_ctrl
//
// Sequencing controller that streams 64-bit image blocks one at a time through
// a combinational DES core (DES_Implementation, instantiated alongside and
// wired to the core_* ports). It holds the key register, applies valid/ready
// handshakes on both sides, gives the core a fixed settle time per block and
// stops after NUM_BLOCKS blocks (one full image).
//
// Optional feature macro: CBC_CHAIN_EN
//   defined   : CBC chaining, core_msg = in_data ^ chain, chain seeded from iv_in
//   undefined : ECB only, core_msg = in_data, iv_in ignored
//
// Parameters
//   NUM_BLOCKS : blocks per run (one image)
//   CNT_W      : block counter width, 2**CNT_W > NUM_BLOCKS
//   CORE_LAT   : settle cycles for the DES core after core_msg changes (1..15)
//
// Ports
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   start              : begin a run (honoured in IDLE/DONE only)
//   key_wr, key_in     : key register load (honoured in IDLE/DONE only)
//   iv_in              : chaining IV (CBC_CHAIN_EN only)
//   in_valid, in_ready, in_data    : plaintext block input handshake
//   out_valid, out_ready, out_data : ciphertext block output handshake
//   core_msg, core_key : registered message/key to the DES core
//   core_enigma        : DES core result
//   busy, done         : run status (ACCEPT/WAIT/OUTPUT, DONE)
//   blk_cnt            : blocks delivered in the current run
// -----------------------------------------------------------------------------
module des_stream_ctrl #(
  parameter int NUM_BLOCKS = 131072,
  parameter int CNT_W      = 18,
  parameter int CORE_LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_wr,
  input  logic [63:0]      key_in,
  input  logic [63:0]      iv_in,
  input  logic             in_valid,
  input  logic [63:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  input  logic             out_ready,
  output logic [63:0]      core_msg,
  output logic [63:0]      core_key,
  input  logic [63:0]      core_enigma,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WAIT,
    OUTPUT,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       settled;
  logic       ctrl_open;
  logic       start_ok;
  logic       in_hs;
  logic       out_hs;
  logic       last_blk;

`ifdef CBC_CHAIN_EN
  logic [63:0] chain;
`else
  logic        unused_iv;
  assign unused_iv = ^iv_in;
`endif

  // Key loads and run starts are only honoured between runs.
  assign ctrl_open = (state == IDLE) || (state == DONE);
  assign start_ok  = start && ctrl_open;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  // The post-increment count equals NUM_BLOCKS exactly when the current
  // count is NUM_BLOCKS-1, so no wider comparator is needed.
  assign last_blk  = (blk_cnt == CNT_W'(NUM_BLOCKS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the purely state-derived status outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ACCEPT;
      end
      ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (settled) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        busy = 1'b1;
        if (out_ready) state_nxt = last_blk ? DONE : ACCEPT;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = ACCEPT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. The settle counter runs down from CORE_LAT-1; reaching zero
  // raises 'settled' for one cycle, and the core result is captured on the
  // edge after that. The extra cycle covers the core_msg register itself, so
  // out_valid rises CORE_LAT+1 edges after the input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_key   <= '0;
      core_msg   <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      blk_cnt    <= '0;
      settle_cnt <= '0;
      settled    <= 1'b0;
`ifdef CBC_CHAIN_EN
      chain      <= '0;
`endif
    end else begin
      if (key_wr && ctrl_open) begin
        core_key <= key_in;
      end

      if (start_ok) begin
        blk_cnt <= '0;
`ifdef CBC_CHAIN_EN
        chain   <= iv_in;
`endif
      end

      if (state == ACCEPT && in_hs) begin
`ifdef CBC_CHAIN_EN
        core_msg <= in_data ^ chain;
`else
        core_msg <= in_data;
`endif
        settle_cnt <= 4'(CORE_LAT - 1);
        settled    <= 1'b0;
      end

      if (state == WAIT) begin
        if (settle_cnt != 4'd0) begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        settled <= (settle_cnt == 4'd0) && !settled;
        if (settled) begin
          out_data  <= core_enigma;
          out_valid <= 1'b1;
        end
      end

      if (state == OUTPUT && out_hs) begin
        out_valid <= 1'b0;
        blk_cnt   <= blk_cnt + CNT_W'(1);
`ifdef CBC_CHAIN_EN
        chain     <= out_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_des_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_des_stream_ctrl
//
// Directed bench for des_stream_ctrl with NUM_BLOCKS=4, CORE_LAT=1. The DES
// core is stood in for by a small combinational function: it returns the
// published DES answer for the standard known-answer key/plaintext pair and a
// simple key/message mix otherwise, which is enough to tell blocks and keys
// apart at the controller's output.
// -----------------------------------------------------------------------------
module tb_des_stream_ctrl;

  localparam int NB   = 4;
  localparam int CW   = 3;
  localparam int CLAT = 1;

  localparam logic [63:0] KAT_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] KAT_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] KEY_FF  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] KEY_2   = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] PT3     = 64'h1122334455667788;
  localparam logic [63:0] PT4     = 64'hDEADBEEFCAFEF00D;

  logic          clk;
  logic          rst;
  logic          start;
  logic          key_wr;
  logic [63:0]   key_in;
  logic [63:0]   iv_in;
  logic          in_valid;
  logic [63:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          out_ready;
  logic [63:0]   core_msg;
  logic [63:0]   core_key;
  logic [63:0]   core_enigma;
  logic          busy;
  logic          done;
  logic [CW-1:0] blk_cnt;

  int          errors;
  int          checks;
  logic [63:0] chain_model;
  logic [63:0] exp_ct;
  logic [63:0] hold_data;

  des_stream_ctrl #(
    .NUM_BLOCKS(NB),
    .CNT_W     (CW),
    .CORE_LAT  (CLAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_wr     (key_wr),
    .key_in     (key_in),
    .iv_in      (iv_in),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .core_msg   (core_msg),
    .core_key   (core_key),
    .core_enigma(core_enigma),
    .busy       (busy),
    .done       (done),
    .blk_cnt    (blk_cnt)
  );

  // Stand-in for the combinational DES core.
  function automatic logic [63:0] fakeDes(input logic [63:0] msg, input logic [63:0] key);
    if (msg == KAT_PT && key == KAT_KEY) begin
      return KAT_CT;
    end
    return {msg[50:0], msg[63:51]} ^ key ^ 64'hA5A50F0F3C3C9696;
  endfunction

  assign core_enigma = fakeDes(core_msg, core_key);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Offer one plaintext block and complete its input handshake.
  task automatic applyStimulus(input logic [63:0] data);
    in_valid = 1'b1;
    in_data  = data;
    for (int i = 0; i < 20 && !in_ready; i++) tick;
    checkOutput("in_ready_seen", 64'(in_ready), 64'd1);
    tick;
    in_valid = 1'b0;
    in_data  = 64'hX;
  endtask

  task automatic waitOutValid;
    for (int i = 0; i < 50 && !out_valid; i++) tick;
    checkOutput("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  // Advance the chain model after an output handshake (CBC builds only).
  task automatic chainStep(input logic [63:0] ct);
`ifdef CBC_CHAIN_EN
    chain_model = ct;
`else
    chain_model = chain_model;
    if (ct === 64'hX) chain_model = 64'd0;
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors      = 0;
    checks      = 0;
    chain_model = 64'd0;
    rst         = 1'b1;
    start       = 1'b0;
    key_wr      = 1'b0;
    key_in      = 64'd0;
    iv_in       = 64'd0;
    in_valid    = 1'b0;
    in_data     = 64'd0;
    out_ready   = 1'b0;
    tick;
    tick;

    checkOutput("rst_in_ready",  64'(in_ready),  64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy",      64'(busy),      64'd0);
    checkOutput("rst_done",      64'(done),      64'd0);
    checkOutput("rst_out_data",  out_data,       64'd0);
    checkOutput("rst_core_msg",  core_msg,       64'd0);
    checkOutput("rst_core_key",  core_key,       64'd0);
    checkOutput("rst_blk_cnt",   64'(blk_cnt),   64'd0);
    rst = 1'b0;

    // Known-answer block: key written in the same cycle as start.
    key_in = KAT_KEY;
    key_wr = 1'b1;
    start  = 1'b1;
    iv_in  = 64'd0;
    tick;
    key_wr = 1'b0;
    start  = 1'b0;
    chain_model = 64'd0;
    checkOutput("kat_core_key", core_key,       KAT_KEY);
    checkOutput("kat_in_ready", 64'(in_ready),  64'd1);
    checkOutput("kat_busy",     64'(busy),      64'd1);

    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = KAT_PT;
    tick;
    in_valid  = 1'b0;
    checkOutput("kat_wait_in_ready", 64'(in_ready),  64'd0);
    checkOutput("kat_core_msg",      core_msg,       KAT_PT ^ chain_model);
    checkOutput("kat_lat_edge1",     64'(out_valid), 64'd0);
    tick;
    checkOutput("kat_lat_edge2_low", 64'(out_valid), 64'd0);
    tick;
    checkOutput("kat_lat_valid",     64'(out_valid), 64'd1);
    checkOutput("kat_out_data",      out_data,       KAT_CT);
    tick;
    chainStep(KAT_CT);
    checkOutput("kat_hs_valid",      64'(out_valid), 64'd0);
    checkOutput("kat_blk_cnt",       64'(blk_cnt),   64'd1);
    checkOutput("kat_back_accept",   64'(in_ready),  64'd1);

    // Block 2: same plaintext, held under backpressure for 10 cycles.
    out_ready = 1'b0;
    applyStimulus(KAT_PT);
    waitOutValid;
    exp_ct = fakeDes(KAT_PT ^ chain_model, KAT_KEY);
    checkOutput("bp_out_data", out_data, exp_ct);
`ifdef CBC_CHAIN_EN
    checkOutput("cbc_second_differs", 64'(out_data != KAT_CT), 64'd1);
`endif
    hold_data = exp_ct;
    for (int i = 0; i < 10; i++) begin
      tick;
      checkOutput("bp_valid_held", 64'(out_valid), 64'd1);
      checkOutput("bp_data_held",  out_data,       hold_data);
      checkOutput("bp_in_ready",   64'(in_ready),  64'd0);
      checkOutput("bp_blk_cnt",    64'(blk_cnt),   64'd1);
    end
    out_ready = 1'b1;
    tick;
    chainStep(exp_ct);
    checkOutput("bp_release_cnt",   64'(blk_cnt),   64'd2);
    checkOutput("bp_release_valid", 64'(out_valid), 64'd0);

    // Block 3: key write attempted while the block is in WAIT.
    applyStimulus(PT3);
    key_in = KEY_FF;
    key_wr = 1'b1;
    tick;
    key_wr = 1'b0;
    checkOutput("lock_core_key", core_key, KAT_KEY);
    waitOutValid;
    exp_ct = fakeDes(PT3 ^ chain_model, KAT_KEY);
    checkOutput("lock_out_data", out_data, exp_ct);
    tick;
    chainStep(exp_ct);
    checkOutput("blk3_cnt", 64'(blk_cnt), 64'd3);

    // Block 4: final block of the run.
    applyStimulus(PT4);
    waitOutValid;
    exp_ct = fakeDes(PT4 ^ chain_model, KAT_KEY);
    checkOutput("blk4_out_data", out_data, exp_ct);
    tick;
    chainStep(exp_ct);
    checkOutput("done_flag",      64'(done),      64'd1);
    checkOutput("done_blk_cnt",   64'(blk_cnt),   64'd4);
    checkOutput("done_in_ready",  64'(in_ready),  64'd0);
    checkOutput("done_busy",      64'(busy),      64'd0);
    checkOutput("done_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b1;
    in_data  = PT3;
    tick;
    in_valid = 1'b0;
    checkOutput("done_hold_cnt",  64'(blk_cnt),   64'd4);
    checkOutput("done_hold_flag", 64'(done),      64'd1);

    // Key write honoured in DONE.
    key_in = KEY_2;
    key_wr = 1'b1;
    tick;
    key_wr = 1'b0;
    checkOutput("done_key_update", core_key, KEY_2);

    // Restart, then reset while the first block is in WAIT.
    start = 1'b1;
    tick;
    start = 1'b0;
    checkOutput("restart_cnt",  64'(blk_cnt), 64'd0);
    checkOutput("restart_busy", 64'(busy),    64'd1);
    applyStimulus(PT3);
    checkOutput("rst_mid_in_wait", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("rst_mid_busy",      64'(busy),      64'd0);
    checkOutput("rst_mid_done",      64'(done),      64'd0);
    checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_blk_cnt",   64'(blk_cnt),   64'd0);
    checkOutput("rst_mid_core_key",  core_key,       64'd0);
    checkOutput("rst_mid_in_ready",  64'(in_ready),  64'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      checkOutput("rst_mid_no_output", 64'(out_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
